// File: rtl/dwconv_accumulator.sv
// rtl/dwconv_accumulator.sv - 16-lane depthwise 3x3 tap multiply-accumulate, emits 32-bit window sums
// Optional tap-order checking enabled by defining DWACC_SEQCHK_EN.
module dwconv_accumulator #(
  parameter int LANES = 16,
  parameter int TAPS  = 9,
  parameter int ACC_W = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [LANES*8-1:0]    act_in,
  input  logic [TAPS*8-1:0]     weight_in,
  input  logic [4:0]            cnt_in,
  input  logic [3:0]            pos_in,
  output logic                  out_valid,
  output logic [4:0]            cnt_out,
  output logic [LANES*32-1:0]   out_data,
  output logic                  busy,
  output logic                  seq_err
);

  localparam logic [3:0] LAST_POS = 4'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t state_q, state_d;

  logic signed [7:0]       tap_w;
  logic signed [15:0]      prod [LANES];
  logic signed [15:0]      p_q  [LANES];
  logic [3:0]              pos_q;
  logic [4:0]              cnt_s1_q;
  logic                    s1_vld;

  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] sum   [LANES];
  logic [4:0]              win_cnt_q;
  logic [3:0]              exp_q, exp_d;
  logic                    do_load, do_acc, do_emit;

  // Out-of-range tap indices select a zero weight so they contribute nothing.
  always_comb begin
    tap_w = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (pos_in == 4'(k)) tap_w = weight_in[8*k +: 8];
    end
    for (int i = 0; i < LANES; i++) begin
      prod[i] = 16'($signed(act_in[8*i +: 8])) * 16'(tap_w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      pos_q    <= '0;
      cnt_s1_q <= '0;
      for (int i = 0; i < LANES; i++) p_q[i] <= '0;
    end else if (en) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        pos_q    <= pos_in;
        cnt_s1_q <= cnt_in;
        for (int i = 0; i < LANES; i++) p_q[i] <= prod[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum[i] = acc_q[i] + ACC_W'(p_q[i]);
    end
  end

`ifdef DWACC_SEQCHK_EN
  logic do_err;
`endif

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    do_load = 1'b0;
    do_acc  = 1'b0;
    do_emit = 1'b0;
`ifdef DWACC_SEQCHK_EN
    do_err  = 1'b0;
`endif
    if (s1_vld) begin
      case (state_q)
        IDLE, DONE: begin
          if (pos_q == 4'd0) begin
            state_d = ACC;
            exp_d   = 4'd1;
            do_load = 1'b1;
          end else begin
            state_d = IDLE;
`ifdef DWACC_SEQCHK_EN
            do_err  = 1'b1;
`else
            do_acc  = 1'b1;
`endif
          end
        end
        ACC: begin
          if (pos_q == 4'd0) begin
            do_load = 1'b1;
            exp_d   = 4'd1;
`ifdef DWACC_SEQCHK_EN
            do_err  = 1'b1;
          end else if (pos_q != exp_q) begin
            do_err  = 1'b1;
            state_d = IDLE;
`endif
          end else if (pos_q == LAST_POS) begin
            do_acc  = 1'b1;
            do_emit = 1'b1;
            state_d = DONE;
          end else begin
            do_acc = 1'b1;
            exp_d  = exp_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // out_valid is a strobe: it drops every cycle, including stalled ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      win_cnt_q <= '0;
      out_valid <= 1'b0;
      cnt_out   <= '0;
      out_data  <= '0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (en) begin
        state_q <= state_d;
        exp_q   <= exp_d;
        if (do_load) begin
          win_cnt_q <= cnt_s1_q;
          for (int i = 0; i < LANES; i++) acc_q[i] <= ACC_W'(p_q[i]);
        end
        if (do_acc) begin
          for (int i = 0; i < LANES; i++) acc_q[i] <= sum[i];
        end
        if (do_emit) begin
          out_valid <= 1'b1;
          cnt_out   <= win_cnt_q;
          for (int i = 0; i < LANES; i++) out_data[32*i +: 32] <= 32'(sum[i]);
        end
      end
    end
  end

`ifdef DWACC_SEQCHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err <= 1'b0;
    end else if (en && do_err) begin
      seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  assign busy = (state_q == ACC);

endmodule

// File: tb/tb_dwconv_accumulator.sv
// tb/tb_dwconv_accumulator.sv - self-checking bench for dwconv_accumulator (window table + scoreboard)
module tb_dwconv_accumulator;
  localparam int LANES = 16;
  localparam int TAPS  = 9;

  logic                 clk = 1'b0;
  logic                 rst, en, in_valid;
  logic [LANES*8-1:0]   act_in;
  logic [TAPS*8-1:0]    weight_in;
  logic [4:0]           cnt_in;
  logic [3:0]           pos_in;
  logic                 out_valid;
  logic [4:0]           cnt_out;
  logic [LANES*32-1:0]  out_data;
  logic                 busy, seq_err;

  always #5 clk = ~clk;

  dwconv_accumulator dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .act_in(act_in), .weight_in(weight_in), .cnt_in(cnt_in), .pos_in(pos_in),
    .out_valid(out_valid), .cnt_out(cnt_out), .out_data(out_data),
    .busy(busy), .seq_err(seq_err)
  );

  typedef struct packed {
    logic [4:0]          cnt;
    logic [LANES*32-1:0] data;
  } exp_t;

  typedef struct packed {
    logic [LANES*8-1:0]  act;
    logic [TAPS*8-1:0]   w;
    logic [4:0]          cnt;
    logic [LANES*32-1:0] sum;
  } vec_t;

  exp_t                sb[$];
  vec_t                vecs[4];
  int                  n_vec = 0, n_err = 0, cyc = 0;
  int                  strobes = 0, last_strobe = -1, prev_strobe = -1;
  int                  base, p8;
  logic [LANES*32-1:0] last_data = '0;

  function automatic logic [LANES*32-1:0] model(input logic [LANES*8-1:0] a, input logic [TAPS*8-1:0] w);
    logic [LANES*32-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      s = 0;
      for (int k = 0; k < TAPS; k++) s += int'($signed(a[8*i +: 8])) * int'($signed(w[8*k +: 8]));
      r[32*i +: 32] = s;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // One clock: monitor outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid) begin
      strobes++;
      prev_strobe = last_strobe;
      last_strobe = cyc;
      last_data   = out_data;
      n_vec++;
      if (!en) begin
        n_err++;
        $display("FAIL strobe_while_stalled: got out_valid=1 required 0");
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got out_valid=1 cnt_out=%0d required no strobe", cnt_out);
      end else begin
        e = sb.pop_front();
        if ({cnt_out, out_data} !== e) begin
          n_err++;
          $display("FAIL window: got cnt=%0d data=%h required cnt=%0d data=%h", cnt_out, out_data, e.cnt, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input logic [LANES*8-1:0] a, input logic [TAPS*8-1:0] w, input logic [4:0] c, input logic [3:0] p);
    in_valid = 1'b1; act_in = a; weight_in = w; cnt_in = c; pos_in = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_window(input vec_t v);
    sb.push_back({v.cnt, v.sum});
    for (int p = 0; p < TAPS; p++) beat(v.act, v.w, v.cnt, 4'(p));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0;
    act_in = '0; weight_in = '0; cnt_in = '0; pos_in = '0;

    for (int i = 0; i < LANES; i++) vecs[0].act[8*i +: 8] = 8'd1;
    for (int k = 0; k < TAPS; k++) vecs[0].w[8*k +: 8] = 8'(k + 1);
    vecs[0].cnt = 5'd5;
    for (int i = 0; i < LANES; i++) vecs[1].act[8*i +: 8] = 8'($urandom);
    vecs[1].act[7:0]  = 8'h80;
    vecs[1].act[15:8] = 8'h7f;
    for (int k = 0; k < TAPS; k++) vecs[1].w[8*k +: 8] = 8'h80;
    vecs[1].cnt = 5'd7;
    for (int v = 2; v < 4; v++) begin
      for (int i = 0; i < LANES; i++) vecs[v].act[8*i +: 8] = 8'($urandom);
      for (int k = 0; k < TAPS; k++) vecs[v].w[8*k +: 8] = 8'($urandom);
      vecs[v].cnt = 5'(v + 1);
    end
    for (int v = 0; v < 4; v++) vecs[v].sum = model(vecs[v].act, vecs[v].w);

    // Reset and idle
    idle(3);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_seq_err", {31'b0, seq_err}, 32'd0);
    chk("rst_cnt_out", {27'b0, cnt_out}, 32'd0);
    chk("rst_out_data", {31'b0, |out_data}, 32'd0);
    rst = 1'b0;
    idle(20);
    chk("idle_no_strobe", strobes, 32'd0);

    // Single window, latency and busy
    sb.push_back({vecs[0].cnt, vecs[0].sum});
    for (int p = 0; p < 4; p++) beat(vecs[0].act, vecs[0].w, vecs[0].cnt, 4'(p));
    chk("busy_mid_window", {31'b0, busy}, 32'd1);
    for (int p = 4; p < TAPS; p++) beat(vecs[0].act, vecs[0].w, vecs[0].cnt, 4'(p));
    p8 = cyc;
    idle(3);
    chk("single_strobe_count", strobes, 32'd1);
    chk("single_latency", last_strobe, p8 + 1);
    chk("single_lane0", last_data[31:0], 32'd45);
    chk("single_lane15", last_data[32*15 +: 32], 32'd45);
    chk("busy_after_window", {31'b0, busy}, 32'd0);

    // Extremes
    send_window(vecs[1]);
    idle(3);
    chk("extreme_lane0", last_data[31:0], 32'd147456);
    chk("extreme_lane1", last_data[63:32], 32'hfffdc480);

    // Stall, bubbles and mid-window cnt change
    base = strobes;
    sb.push_back({vecs[0].cnt, vecs[0].sum});
    for (int p = 0; p < 4; p++) beat(vecs[0].act, vecs[0].w, vecs[0].cnt, 4'(p));
    en = 1'b0;
    in_valid = 1'b1; act_in = vecs[1].act; weight_in = vecs[1].w; pos_in = 4'd0; cnt_in = 5'd9;
    idle(4);
    chk("busy_held_in_stall", {31'b0, busy}, 32'd1);
    en = 1'b1; in_valid = 1'b0;
    beat(vecs[0].act, vecs[0].w, 5'd9, 4'd4);
    idle(1);
    beat(vecs[0].act, vecs[0].w, 5'd9, 4'd5);
    idle(2);
    for (int p = 6; p < TAPS; p++) beat(vecs[0].act, vecs[0].w, 5'd9, 4'(p));
    idle(3);
    chk("stall_strobe_count", strobes - base, 32'd1);
    chk("stall_lane3", last_data[32*3 +: 32], 32'd45);

    // Back-to-back windows
    base = strobes;
    send_window(vecs[2]);
    send_window(vecs[3]);
    idle(3);
    chk("b2b_strobe_count", strobes - base, 32'd2);
    chk("b2b_spacing", last_strobe - prev_strobe, 32'd9);

    // Out-of-order taps
    base = strobes;
    beat(vecs[0].act, vecs[0].w, 5'd1, 4'd0);
    beat(vecs[0].act, vecs[0].w, 5'd1, 4'd1);
    beat(vecs[0].act, vecs[0].w, 5'd1, 4'd3);
    idle(3);
`ifdef DWACC_SEQCHK_EN
    chk("order_seq_err", {31'b0, seq_err}, 32'd1);
    chk("order_busy", {31'b0, busy}, 32'd0);
`else
    chk("order_seq_err", {31'b0, seq_err}, 32'd0);
    chk("order_busy", {31'b0, busy}, 32'd1);
`endif
    chk("order_no_strobe", strobes - base, 32'd0);
    send_window(vecs[2]);
    idle(3);
    chk("order_recover", strobes - base, 32'd1);

    // Reset mid-window
    base = strobes;
    for (int p = 0; p < 5; p++) beat(vecs[1].act, vecs[1].w, vecs[1].cnt, 4'(p));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_out_data", out_data[31:0], 32'd0);
    for (int p = 5; p < TAPS; p++) beat(vecs[1].act, vecs[1].w, vecs[1].cnt, 4'(p));
    idle(3);
    chk("midrst_no_strobe", strobes - base, 32'd0);
    send_window(vecs[3]);
    idle(3);
    chk("midrst_recover", strobes - base, 32'd1);

    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
